rr_sel_ctrl: RTL and testbench

Round-robin selection controller placed directly upstream of the 4:1 8-bit multiplexer (`mux4t1_8b`). It arbitrates among four requesting sources and drives the mux `Sel` input. It captures the mux output byte into a registered output with a valid/ready handshake. It turns the purely combinational mux into a fair, flow-controlled 4-to-1 byte funnel.

---
 rtl/rr_sel_pkg.sv | 22 ++
 rtl/mux4t1_8b.sv | 24 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/rr_sel_ctrl.sv | 123 ++++++++++++
 tb/tb_rr_sel_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_sel_pkg.sv
// rr_sel_pkg: shared definitions for the round-robin selection controller.
//   - FSM state encoding (IDLE / SEL / OUT)
//   - number of sources and reset value of the last-served pointer
//   - onehot4(): 2-bit index to 4-bit one-hot grant
package rr_sel_pkg;

    localparam int N_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Last-served pointer at reset; 3 makes source 0 the first to be scanned.
    localparam logic [1:0] LAST_RST = 2'b11;

    function automatic logic [N_SRC-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4t1_8b.sv
// mux4t1_8b: purely combinational 4:1 byte multiplexer driven by rr_sel_ctrl.
// Ports:
//   A,B,C,D in 8  data inputs (Sel = 0,1,2,3)
//   Sel     in 2  select
//   F       out 8 selected byte
module mux4t1_8b (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic [7:0] D,
    input  logic [1:0] Sel,
    output logic [7:0] F
);

    always_comb begin
        case (Sel)
            2'd0:    F = A;
            2'd1:    F = B;
            2'd2:    F = C;
            default: F = D;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way priority picker with a movable start point.
// Ports:
//   Req   in  4  request vector
//   Start in  2  index scanned first; the scan wraps 3 -> 0
//   Any   out 1  at least one request is set
//   Win   out 2  first set request found from Start upward (Start when none)
module rr_pick4 (
    input  logic [3:0] Req,
    input  logic [1:0] Start,
    output logic       Any,
    output logic [1:0] Win
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        Any   = |Req;
        Win   = Start;
        idx   = Start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit add wraps naturally past source 3 back to source 0
            idx = Start + 2'(i);
            if (!found && Req[idx]) begin
                Win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_ctrl.sv
// rr_sel_ctrl: round-robin arbiter that drives the Sel input of mux4t1_8b and
// captures the mux output into a registered byte with a valid/ready handshake.
//
// Ports:
//   Clk        in  1       rising-edge clock
//   Rst_n      in  1       asynchronous active-low reset
//   Req        in  4       per-source request (source i on mux input i)
//   Mux_F      in  DATA_W  mux output fed back for capture
//   Sel        out 2       registered mux select, held outside SEL
//   Gnt        out 4       one-hot grant, pulses during the capture cycle
//   Out        out DATA_W  captured byte
//   Out_Valid  out 1       Out holds an unconsumed byte
//   Out_Ready  in  1       downstream accepts Out on Out_Valid && Out_Ready
//
// Build option: define RR_SEL_FIXED_PRI_EN for fixed priority (source 0
// highest). The default build is round-robin with a last-served pointer.
module rr_sel_ctrl
    import rr_sel_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [3:0]        Req,
    input  logic [DATA_W-1:0] Mux_F,
    output logic [1:0]        Sel,
    output logic [3:0]        Gnt,
    output logic [DATA_W-1:0] Out,
    output logic              Out_Valid,
    input  logic              Out_Ready
);

    state_t            state, state_nx;
    logic [1:0]        sel_nx;
    logic [3:0]        gnt_nx;
    logic [DATA_W-1:0] out_nx;
    logic              valid_nx;

    logic [1:0]        start;
    logic              any;
    logic [1:0]        win;

`ifdef RR_SEL_FIXED_PRI_EN
    assign start = 2'b00;
`else
    logic [1:0] last, last_nx;
    // Scan begins just past the source served most recently.
    assign start = last + 2'd1;
`endif

    rr_pick4 u_pick (
        .Req   (Req),
        .Start (start),
        .Any   (any),
        .Win   (win)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            Sel       <= 2'b00;
            Gnt       <= 4'b0000;
            Out       <= '0;
            Out_Valid <= 1'b0;
`ifndef RR_SEL_FIXED_PRI_EN
            last      <= LAST_RST;
`endif
        end else begin
            state     <= state_nx;
            Sel       <= sel_nx;
            Gnt       <= gnt_nx;
            Out       <= out_nx;
            Out_Valid <= valid_nx;
`ifndef RR_SEL_FIXED_PRI_EN
            last      <= last_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = Sel;
        gnt_nx   = 4'b0000;   // grant is a single-cycle pulse
        out_nx   = Out;
        valid_nx = Out_Valid;
`ifndef RR_SEL_FIXED_PRI_EN
        last_nx  = last;
`endif
        case (state)
            ST_IDLE: begin
                if (any) begin
                    sel_nx   = win;
                    gnt_nx   = onehot4(win);
                    state_nx = ST_SEL;
                end
            end
            ST_SEL: begin
                // Sel has been stable a full cycle, so Mux_F has settled.
                out_nx   = Mux_F;
                valid_nx = 1'b1;
`ifndef RR_SEL_FIXED_PRI_EN
                last_nx  = Sel;
`endif
                state_nx = ST_OUT;
            end
            ST_OUT: begin
                if (Out_Valid && Out_Ready) begin
                    valid_nx = 1'b0;
                    // Re-arbitrate on the handshake edge to keep 2-cycle throughput.
                    if (any) begin
                        sel_nx   = win;
                        gnt_nx   = onehot4(win);
                        state_nx = ST_SEL;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_sel_ctrl.sv
module tb_rr_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] mux_f;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbq[$];
    int         exp_last;

    always #5 clk = ~clk;

    mux4t1_8b u_mux (
        .A   (8'h01),
        .B   (8'h02),
        .C   (8'h04),
        .D   (8'h08),
        .Sel (sel),
        .F   (mux_f)
    );

    rr_sel_ctrl #(.DATA_W(8)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Req       (req),
        .Mux_F     (mux_f),
        .Sel       (sel),
        .Gnt       (gnt),
        .Out       (out),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready)
    );

    // Reference arbitration: first set request scanning from the start point.
    function automatic int predict(input logic [3:0] r, input int last);
        int start;
        int idx;
`ifdef RR_SEL_FIXED_PRI_EN
        start = 0;
`else
        start = (last + 1) % 4;
`endif
        for (int i = 0; i < 4; i++) begin
            idx = (start + i) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'h0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = 3;
        sbq.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'hF;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sel !== 2'b00)   begin failures++; $display("FAIL reset_sel got=%b exp=00", sel); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (out !== 8'h00)   begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || sel !== 2'b00)
            begin failures++; $display("FAIL first_grant got gnt=%b sel=%b exp gnt=0001 sel=00", gnt, sel); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out !== 8'h01 || gnt !== 4'b0000)
            begin failures++; $display("FAIL first_out got v=%b out=%h gnt=%b exp v=1 out=01 gnt=0000", out_valid, out, gnt); end
        reset_pulse();
    endtask

    task automatic test_round_robin();
        logic [7:0] seq [5];
        int k = 0, vcnt = 0, w;
        logic prev_v = 1'b0, dbl = 1'b0;
        logic [3:0] eg;
        logic [7:0] e;
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h01;
        req = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                w = predict(req, exp_last);
                eg = (w < 0) ? 4'b0 : 4'(4'b0001 << w);
                checks++;
                if (w < 0 || gnt !== eg || sel !== 2'(w)) begin
                    failures++; $display("FAIL rr_grant got gnt=%b sel=%b exp gnt=%b", gnt, sel, eg);
                end else begin
                    sbq.push_back(8'(8'h01 << w)); exp_last = w;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin failures++; $display("FAIL rr_out_unexpected got=%h exp=none", out); end
                else begin
                    e = sbq.pop_front();
                    if (out !== e) begin failures++; $display("FAIL rr_out got=%h exp=%h", out, e); end
                end
                if (k < 5) begin
                    checks++;
                    if (out !== seq[k]) begin failures++; $display("FAIL rr_seq[%0d] got=%h exp=%h", k, out, seq[k]); end
                    k++;
                end
            end
            if (out_valid && prev_v) dbl = 1'b1;
            if (out_valid) vcnt++;
            prev_v = out_valid;
        end
        checks++; if (vcnt != 6 || dbl) begin failures++; $display("FAIL rr_valid_rate got=%0d dbl=%b exp=6 dbl=0", vcnt, dbl); end
        checks++; if (k != 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", k); end
        reset_pulse();
    endtask

    task automatic test_skip_wrap();
        int w, hs = 0;
        logic bad = 1'b0;
        logic [3:0] eg;
        logic [7:0] e;
        req = 4'b1010; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((gnt & 4'b0101) != 4'b0) bad = 1'b1;
            if (gnt != 4'b0) begin
                w = predict(req, exp_last);
                eg = (w < 0) ? 4'b0 : 4'(4'b0001 << w);
                checks++;
                if (w < 0 || gnt !== eg || sel !== 2'(w)) begin
                    failures++; $display("FAIL skip_grant got gnt=%b sel=%b exp gnt=%b", gnt, sel, eg);
                end else begin
                    sbq.push_back(8'(8'h01 << w)); exp_last = w;
                end
            end
            if (out_valid && out_ready) begin
                hs++;
                checks++;
                if (sbq.size() == 0) begin failures++; $display("FAIL skip_out_unexpected got=%h exp=none", out); end
                else begin
                    e = sbq.pop_front();
                    if (out !== e) begin failures++; $display("FAIL skip_out got=%h exp=%h", out, e); end
                end
            end
        end
        checks++; if (bad) begin failures++; $display("FAIL skip_never_granted got=granted exp=none"); end
        checks++; if (hs != 6) begin failures++; $display("FAIL skip_count got=%0d exp=6", hs); end
        reset_pulse();
    endtask

    task automatic test_backpressure();
        int w;
        logic [7:0] e;
        req = 4'b0100; out_ready = 1'b0;
        @(negedge clk);
        w = predict(req, exp_last);
        checks++;
        if (w != 2 || gnt !== 4'b0100 || sel !== 2'd2) begin
            failures++; $display("FAIL bp_grant got gnt=%b sel=%b exp gnt=0100 sel=10", gnt, sel);
        end else begin
            sbq.push_back(8'h04); exp_last = w;
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out !== 8'h04 || out_valid !== 1'b1 || gnt !== 4'b0000 || sel !== 2'd2) begin
                failures++; $display("FAIL bp_hold[%0d] got out=%h v=%b gnt=%b sel=%b exp out=04 v=1 gnt=0000 sel=10",
                                     c, out, out_valid, gnt, sel);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (sbq.size() == 0) begin failures++; $display("FAIL bp_out_unexpected got=%h exp=none", out); end
        else begin
            e = sbq.pop_front();
            if (out !== e || out_valid !== 1'b1) begin failures++; $display("FAIL bp_out got=%h v=%b exp=%h v=1", out, out_valid, e); end
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_regrant got gnt=%b v=%b exp gnt=0100 v=0", gnt, out_valid);
        end
        reset_pulse();
    endtask

    task automatic test_mid_reset();
        req = 4'b0001; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h01) begin
            failures++; $display("FAIL mid_pre got v=%b out=%h exp v=1 out=01", out_valid, out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || sel !== 2'b00 || gnt !== 4'b0000) begin
            failures++; $display("FAIL mid_reset got v=%b out=%h sel=%b gnt=%b exp 0/00/00/0000", out_valid, out, sel, gnt);
        end
        @(negedge clk);
        req = 4'h0;
        rst_n = 1'b1;
        exp_last = 3;
        sbq.delete();
        reset_pulse();
    endtask

`ifdef RR_SEL_FIXED_PRI_EN
    task automatic test_fixed();
        int w, hs;
        logic [3:0] eg;
        logic [7:0] e;
        for (int ph = 0; ph < 2; ph++) begin
            req = (ph == 0) ? 4'hF : 4'hE;
            out_ready = 1'b1;
            hs = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (gnt != 4'b0) begin
                    w = predict(req, exp_last);
                    eg = (w < 0) ? 4'b0 : 4'(4'b0001 << w);
                    checks++;
                    if (w < 0 || gnt !== eg) begin
                        failures++; $display("FAIL fixed_grant got=%b exp=%b", gnt, eg);
                    end else begin
                        sbq.push_back(8'(8'h01 << w));
                    end
                end
                if (out_valid && out_ready) begin
                    hs++;
                    checks++;
                    e = (sbq.size() == 0) ? 8'hxx : sbq.pop_front();
                    if (out !== e || out !== ((ph == 0) ? 8'h01 : 8'h02)) begin
                        failures++; $display("FAIL fixed_out ph=%0d got=%h exp=%h", ph, out, e);
                    end
                end
            end
            checks++; if (hs != 5) begin failures++; $display("FAIL fixed_count ph=%0d got=%0d exp=5", ph, hs); end
            reset_pulse();
        end
    endtask
`endif

    initial begin
        exp_last = 3;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_mid_reset();
`ifdef RR_SEL_FIXED_PRI_EN
        test_fixed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
